// File: rtl/shift_seq_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | shift_seq_ctrl: two-requester round-robin arbiter feeding an MSB-first     |
// | serial shifter. Optional trailing even-parity bit: SHIFT_SEQ_PARITY_EN.    |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module shift_seq_ctrl #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0,
  input  logic [WIDTH-1:0] din0,
  input  logic             req1,
  input  logic [WIDTH-1:0] din1,
  output logic             gnt0,
  output logic             gnt1,
  output logic             sout,
  output logic             sout_valid,
  output logic             owner,
  output logic             busy,
  output logic             done
);

  localparam int             CNT_W    = $clog2(WIDTH) + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SHIFT = 2'd1;
  localparam logic [1:0] ST_DONE  = 2'd3;
`ifdef SHIFT_SEQ_PARITY_EN
  localparam logic [1:0] ST_PAR   = 2'd2;
`endif

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             last_owner_q, last_owner_d;
  logic             owner_q, owner_d;
  logic             gnt0_q, gnt0_d;
  logic             gnt1_q, gnt1_d;
  logic             sel;
  logic [WIDTH-1:0] sel_word;
`ifdef SHIFT_SEQ_PARITY_EN
  logic             par_q, par_d;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      shreg_q      <= '0;
      cnt_q        <= '0;
      last_owner_q <= 1'b1;
      owner_q      <= 1'b0;
      gnt0_q       <= 1'b0;
      gnt1_q       <= 1'b0;
`ifdef SHIFT_SEQ_PARITY_EN
      par_q        <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      shreg_q      <= shreg_d;
      cnt_q        <= cnt_d;
      last_owner_q <= last_owner_d;
      owner_q      <= owner_d;
      gnt0_q       <= gnt0_d;
      gnt1_q       <= gnt1_d;
`ifdef SHIFT_SEQ_PARITY_EN
      par_q        <= par_d;
`endif
    end
  end

  always_comb begin
    state_d      = state_q;
    shreg_d      = shreg_q;
    cnt_d        = cnt_q;
    last_owner_d = last_owner_q;
    owner_d      = owner_q;
    gnt0_d       = 1'b0;
    gnt1_d       = 1'b0;
    // On a tie, the requester that did not win last time is chosen.
    sel          = req1 & (~req0 | ~last_owner_q);
    sel_word     = sel ? din1 : din0;
`ifdef SHIFT_SEQ_PARITY_EN
    par_d        = par_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (req0 | req1) begin
          shreg_d      = sel_word;
          owner_d      = sel;
          last_owner_d = sel;
          cnt_d        = '0;
          gnt0_d       = ~sel;
          gnt1_d       = sel;
`ifdef SHIFT_SEQ_PARITY_EN
          par_d        = ^sel_word;
`endif
          state_d      = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        shreg_d = {shreg_q[WIDTH-2:0], 1'b0};
        cnt_d   = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_LAST) begin
`ifdef SHIFT_SEQ_PARITY_EN
          state_d = ST_PAR;
`else
          state_d = ST_DONE;
`endif
        end
      end
`ifdef SHIFT_SEQ_PARITY_EN
      ST_PAR:  state_d = ST_DONE;
`endif
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    sout       = 1'b0;
    sout_valid = 1'b0;
    case (state_q)
      ST_SHIFT: begin
        sout       = shreg_q[WIDTH-1];
        sout_valid = 1'b1;
      end
`ifdef SHIFT_SEQ_PARITY_EN
      ST_PAR: begin
        sout       = par_q;
        sout_valid = 1'b1;
      end
`endif
      default: ;
    endcase
    busy  = (state_q != ST_IDLE);
    done  = (state_q == ST_DONE);
    gnt0  = gnt0_q;
    gnt1  = gnt1_q;
    owner = owner_q;
  end

endmodule
`default_nettype wire

// File: tb/tb_shift_seq_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_shift_seq_ctrl: directed bench with a frame-level reference model.      |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_shift_seq_ctrl;
  localparam int W = 4;
`ifdef SHIFT_SEQ_PARITY_EN
  localparam int PB = 1;
`else
  localparam int PB = 0;
`endif
  localparam int FRAME      = W + PB;
  localparam int EXP_DONE   = FRAME + 1;
  localparam int EXP_PERIOD = FRAME + 2;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         req0 = 1'b0, req1 = 1'b0;
  logic [W-1:0] din0 = '0, din1 = '0;
  logic         gnt0, gnt1, sout, sout_valid, owner, busy, done;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  shift_seq_ctrl #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .req0(req0), .din0(din0), .req1(req1), .din1(din1),
    .gnt0(gnt0), .gnt1(gnt1), .sout(sout), .sout_valid(sout_valid),
    .owner(owner), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Reference model: m_k is the cycle number within the current frame (0 = idle).
  int           m_k = 0;
  logic [W-1:0] m_word = '0;
  logic         m_owner = 1'b0;
  logic         m_last = 1'b1;

  function automatic logic pick();
    return (req0 && req1) ? !m_last : req1;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_k     <= 0;
      m_word  <= '0;
      m_owner <= 1'b0;
      m_last  <= 1'b1;
    end else if (m_k == 0) begin
      if (req0 || req1) begin
        m_owner <= pick();
        m_last  <= pick();
        m_word  <= pick() ? din1 : din0;
        m_k     <= 1;
      end
    end else if (m_k == FRAME + 1) begin
      m_k <= 0;
    end else begin
      m_k <= m_k + 1;
    end
  end

  function automatic logic exp_sout();
    if (m_k >= 1 && m_k <= W) return m_word[W - m_k];
    if (PB == 1 && m_k == W + 1) return ^m_word;
    return 1'b0;
  endfunction

  always @(negedge clk) begin
    check("gnt0",       gnt0,       int'(m_k == 1 && !m_owner));
    check("gnt1",       gnt1,       int'(m_k == 1 && m_owner));
    check("sout",       sout,       exp_sout());
    check("sout_valid", sout_valid, int'(m_k >= 1 && m_k <= FRAME));
    check("busy",       busy,       int'(m_k != 0));
    check("done",       done,       int'(m_k == FRAME + 1));
    check("owner",      owner,      m_owner);
  end

  // Waits for a grant and captures one frame; ends on the idle cycle after done.
  task automatic frame(input bit drop, output int who, output logic [W-1:0] bits,
                       output logic pbit, output int gcyc, output int dk);
    int n;
    who = -1; bits = '0; pbit = 1'b0; gcyc = 0; dk = 0; n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(gnt0 || gnt1) && n < 40);
    check("grant_seen", int'(gnt0 || gnt1), 1);
    if (!(gnt0 || gnt1)) return;
    who  = gnt1 ? 1 : 0;
    gcyc = cyc;
    if (drop) begin
      req0 = 1'b0;
      req1 = 1'b0;
    end
    for (int k = 1; k <= FRAME + 2; k++) begin
      if (k > 1) @(negedge clk);
      if (k <= W) bits = {bits[W-2:0], sout};
      else if (PB == 1 && k == W + 1) pbit = sout;
      if (done && dk == 0) dk = k;
    end
  endtask

  int           who, g1, g2, g3, dk;
  logic [W-1:0] bits;
  logic         pbit;

  initial begin
    repeat (2) @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_owner", owner, 0);
    check("rst_valid", sout_valid, 0);
    rst = 1'b0;

    // Single transfer from requester 0
    @(negedge clk);
    req0 = 1'b1; din0 = 4'b1011;
    frame(1, who, bits, pbit, g1, dk);
    check("single_who", who, 0);
    check("single_bits", bits, 4'b1011);
    check("single_done_cycle", dk, EXP_DONE);
`ifdef SHIFT_SEQ_PARITY_EN
    check("parity_1011", pbit, 1);
    req0 = 1'b1; din0 = 4'b0011;
    frame(1, who, bits, pbit, g1, dk);
    check("parity_bits", bits, 4'b0011);
    check("parity_0011", pbit, 0);
`endif

    // Asynchronous reset mid-transfer with both requests held
    req0 = 1'b1; req1 = 1'b1; din0 = 4'hA; din1 = 4'h5;
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("arst_gnt0", gnt0, 0);
    check("arst_gnt1", gnt1, 0);
    check("arst_sout", sout, 0);
    check("arst_valid", sout_valid, 0);
    check("arst_busy", busy, 0);
    check("arst_done", done, 0);
    check("arst_owner", owner, 0);
    @(negedge clk);
    #2 rst = 1'b0;
    #1;
    check("release_no_gnt", int'(gnt0 || gnt1), 0);

    // Tie arbitration alternates starting with requester 0
    frame(0, who, bits, pbit, g1, dk);
    check("tie1_who", who, 0);
    check("tie1_bits", bits, 4'hA);
    frame(0, who, bits, pbit, g2, dk);
    check("tie2_who", who, 1);
    check("tie2_bits", bits, 4'h5);
    frame(1, who, bits, pbit, g3, dk);
    check("tie3_who", who, 0);
    check("tie3_bits", bits, 4'hA);
    check("tie_gap12", g2 - g1, EXP_PERIOD);
    check("tie_gap23", g3 - g2, EXP_PERIOD);

    // Requester 1 alone, held continuously
    req1 = 1'b1; din1 = 4'h9;
    frame(0, who, bits, pbit, g1, dk);
    check("rep1_who", who, 1);
    check("rep1_bits", bits, 4'h9);
    frame(0, who, bits, pbit, g2, dk);
    check("rep2_who", who, 1);
    frame(1, who, bits, pbit, g3, dk);
    check("rep3_who", who, 1);
    check("rep_gap12", g2 - g1, EXP_PERIOD);
    check("rep_gap23", g3 - g2, EXP_PERIOD);

    // Reset in cycle 2 of a transfer, then tied requests resume from requester 0
    req0 = 1'b1; req1 = 1'b1; din0 = 4'hC; din1 = 4'h3;
    @(negedge clk);
    @(negedge clk);
    check("mid_valid_before", sout_valid, 1);
    #2 rst = 1'b1;
    #1;
    check("mid_valid_drop", sout_valid, 0);
    check("mid_no_done", done, 0);
    @(negedge clk);
    #2 rst = 1'b0;
    frame(0, who, bits, pbit, g1, dk);
    check("post_rst_who0", who, 0);
    check("post_rst_bits0", bits, 4'hC);
    frame(1, who, bits, pbit, g2, dk);
    check("post_rst_who1", who, 1);
    check("post_rst_bits1", bits, 4'h3);

    repeat (4) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/shift_seq_ctrl.md
# shift_seq_ctrl

Serial shift sequencer and arbiter for the team's serial shift-register datapath. Two requesters each present a parallel word. The block grants one requester round-robin, loads that word into an internal shift register, and shifts it out MSB-first on a single serial line with a valid strobe. It pulses `done` when the word is finished. It sits between parallel producers and any serial-in shift chain, which consumes `sout` qualified by `sout_valid`.

## Interface
- `WIDTH`, default 4: data word width in bits; legal range 2..16.
- `clk`  in  1: sole clock; all state updates on its rising edge.
- `rst`  in  1: reset, asynchronous and active-high.
- `req0`  in  1: requester 0 wants a transfer; held high until `gnt0`.
- `din0`  in  WIDTH: requester 0 word; must be stable while `req0` is high.
- `req1`  in  1: requester 1 request; same rules as `req0`.
- `din1`  in  WIDTH: requester 1 word.
- `gnt0`  out  1: one-cycle pulse; `din0` was captured on the preceding edge.
- `gnt1`  out  1: one-cycle pulse; `din1` was captured.
- `sout`  out  1: serial data, MSB first.
- `sout_valid`  out  1: `sout` carries a data bit, or the parity bit when parity is enabled.
- `owner`  out  1: index of the requester whose word is in flight.
- `busy`  out  1: high in any state other than IDLE.
- `done`  out  1: one-cycle pulse after the last serial bit.

## Operation
- State machine states: IDLE, SHIFT, PAR (parity build only), DONE.
- **IDLE**
  - If neither request is high, stay in IDLE.
  - If exactly one request is high, grant it.
  - If both are high, grant the requester that is not `last_owner`.
  - On the grant edge: load the selected word into `shreg`, set `owner` and `last_owner` to the winner, clear `cnt`, pulse that requester's `gnt`, go to SHIFT.
- **SHIFT**
  - `sout` = `shreg[WIDTH-1]` and `sout_valid` = 1 throughout.
  - On each edge: shift `shreg` left with 0 fill and increment `cnt`.
  - After WIDTH bits (`cnt` = WIDTH-1 at the edge), go to PAR if parity is compiled in, otherwise to DONE.
- **PAR**: `sout` = XOR of the captured word (even parity), `sout_valid` = 1; next state DONE.
- **DONE**: `done` = 1, `sout_valid` = 0; next state IDLE.
- Requests are sampled only in IDLE. A request raised while busy waits; it is not lost, because the requester holds it until granted.
- `cnt` width is clog2(WIDTH)+1; it never wraps within a transfer.
- Outputs when not in SHIFT or PAR: `sout` = 0, `sout_valid` = 0.

## Timing
- Reset values: state IDLE, `shreg` 0, `cnt` 0, `last_owner` 1 (requester 0 wins the first tie), `owner` 0, and all outputs 0.
- Reset mid-transfer: takes effect immediately and asynchronously. The transfer is abandoned, `done` is not pulsed, and `gnt` is not re-issued.
- Call the grant edge E0. Data bit k (k = 0 is the MSB) appears in cycle k+1 after E0.
  - `gnt` is high in cycle 1, together with the MSB.
  - Without parity: `done` is high in cycle WIDTH+1.
  - With parity: the parity bit is in cycle WIDTH+1 and `done` in cycle WIDTH+2.
- Earliest next grant is the edge ending the cycle after `done`, because IDLE lasts at least one cycle.
  - Back-to-back transfer period is WIDTH+2 cycles, or WIDTH+3 with parity.
- `busy` is high from cycle 1 through the `done` cycle inclusive.
- All outputs are registered or decoded purely from registered state; there is no combinational path from any input to any output.

## Configuration
- Macro: `SHIFT_SEQ_PARITY_EN`.
- Defined: the PAR state exists and one even-parity bit follows the LSB with `sout_valid` = 1.
- Undefined: there is no PAR state, SHIFT goes directly to DONE, and the frame is exactly WIDTH bits.

## Test plan
- **Reset:** assert `rst` mid-cycle with the requests high -> all outputs 0 immediately; after release, no `gnt` is issued until the next edge in IDLE.
- **Single transfer, parity off:** WIDTH=4, `req0`=1, `din0`=4'b1011 -> `gnt0` in cycle 1; `sout` = 1,0,1,1 in cycles 1-4 with `sout_valid`=1; `done` in cycle 5; `owner`=0.
- **Tie arbitration:** `req0` and `req1` both held with `din0`=4'hA, `din1`=4'h5 -> first grant to 0 (serial 1010), then to 1 (serial 0101), then 0 again. Grant edges are 6 cycles apart.
- **Single requester repeated:** `req1` held continuously, `req0` low -> `gnt1` every 6 cycles and requester 0 never granted.
- **Parity on (`SHIFT_SEQ_PARITY_EN` defined):** `din0`=4'b1011 -> serial 1,0,1,1 then parity 1 in cycle 5; `done` in cycle 6. `din0`=4'b0011 -> parity 0.
- **Reset mid-shift:** `rst` pulsed in cycle 2 of a transfer -> `sout_valid` drops immediately and no `done` pulse follows. A held `req1` with tied requests is then granted after requester 0, since `last_owner` resets to 1.
